// File: rtl/fifo_arb_pkg.sv
// Shared types and the rotate-priority selection function for fifo_wr_arbiter.
// Optional statistics are enabled with FIFO_WR_ARBITER_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;

  localparam int STALL_CNT_W = 16;
  localparam int RR_MAX      = 8;

  // Returns {found, index}. The scan runs from the highest offset down, so the
  // last hit written is the one closest to ptr.
  function automatic logic [3:0] rr_select(input logic [RR_MAX-1:0] req,
                                           input logic [2:0]        ptr,
                                           input int                n);
    logic [3:0] res;
    int         idx;
    res = '0;
    for (int k = RR_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: the first set request at or after ptr.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [RR_MAX-1:0] req_pad;
  logic [2:0]        ptr_pad;
  logic [3:0]        sel;
  logic              unused_sel;

  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req;
    ptr_pad                = '0;
    ptr_pad[ID_W-1:0]      = ptr;
    sel                    = rr_select(req_pad, ptr_pad, NUM_REQ);
  end

  assign found      = sel[3];
  assign idx        = sel[ID_W-1:0];
  assign unused_sel = ^sel;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter sharing one fifo_sync write port.
// Define FIFO_WR_ARBITER_STATS_EN to add the stall_cnt / stats_clr statistics.
//
// state | meaning
// IDLE  | no owner; picks from rr_ptr when any req is set
// BURST | owner holds the write port for up to BURST_LEN accepted beats
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  input  logic                          stats_clr,
  output logic [STALL_CNT_W-1:0]        stall_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(BURST_LEN) + 1;

  localparam logic [0:0] S_IDLE  = 1'(IDLE);
  localparam logic [0:0] S_BURST = 1'(BURST);

  logic [0:0]         state;
  logic [ID_W-1:0]    owner;
  logic [ID_W-1:0]    rr_ptr;
  logic [BC_W-1:0]    beat_cnt;

  logic               in_burst;
  logic               owner_req;
  logic               accept;
  logic               last_beat;
  logic               release_now;
  logic [ID_W-1:0]    next_ptr;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] rel_req;
  logic               idle_found;
  logic [ID_W-1:0]    idle_idx;
  logic               rel_found;
  logic [ID_W-1:0]    rel_idx;

  assign in_burst    = (state == S_BURST);
  assign owner_req   = req[owner];
  // rst gates the write so nothing lands in the FIFO during a reset cycle
  assign accept      = in_burst & owner_req & ~fifo_full & rst;
  assign last_beat   = (beat_cnt == BC_W'(BURST_LEN - 1));
  assign release_now = in_burst & (~owner_req | (accept & last_beat));
  assign next_ptr    = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  // The owner never regrants itself directly; a lone requester goes via IDLE.
  assign rel_req = req & ~owner_oh;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_idle_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .found (idle_found),
    .idx   (idle_idx)
  );

  rr_picker #(.NUM_REQ(NUM_REQ)) u_rel_pick (
    .req   (rel_req),
    .ptr   (next_ptr),
    .found (rel_found),
    .idx   (rel_idx)
  );

  assign fifo_wr_en = accept;
  assign ack        = accept ? owner_oh : '0;
  assign fifo_din   = in_burst ? data[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign gnt_valid  = in_burst;
  assign gnt_id     = in_burst ? owner : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (idle_found) begin
            state    <= S_BURST;
            owner    <= idle_idx;
            beat_cnt <= '0;
          end
        end
        default: begin
          if (release_now) begin
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
            if (rel_found) begin
              owner <= rel_idx;
            end else begin
              state <= S_IDLE;
            end
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic stall;
  assign stall = in_burst & owner_req & fifo_full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stats_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with a depth-8 FIFO occupancy model.
// Stall statistics are checked when FIFO_WR_ARBITER_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic        stats_clr;
  logic [15:0] stall_cnt;
`endif

  logic [3:0]  fifo_count;
  logic        fifo_rd;
  logic        tb_push;

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data       (data),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Occupancy model of a depth-8 fifo_sync
  always_ff @(posedge clk) begin
    if (!rst) fifo_count <= '0;
    else fifo_count <= fifo_count + 4'((fifo_wr_en || tb_push) ? 1 : 0)
                                  - 4'((fifo_rd && fifo_count != 0) ? 1 : 0);
  end
  assign fifo_full = (fifo_count == 4'd8);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0; req = '0; fifo_rd = 1'b0; tb_push = 1'b0;
`ifdef FIFO_WR_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b1111; data = 32'h1312_1110; fifo_rd = 1'b0; tb_push = 1'b0;
`ifdef FIFO_WR_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en c%0d: got %b expected 0", c, fifo_wr_en); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack c%0d: got %b expected 0000", c, ack); end
      checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid c%0d: got %b expected 0", c, gnt_valid); end
    end
    rst = 1'b1;
    tick(); #1;
    checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL reset_first_gnt_valid: got %b expected 1", gnt_valid); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_first_gnt_id: got %0d expected 0", gnt_id); end
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL reset_first_ack: got %b expected 0001", ack); end
    checks++; if (fifo_din !== 8'h10) begin errors++; $display("FAIL reset_first_din: got %h expected 10", fifo_din); end
  endtask

  task automatic test_single();
    do_reset();
    data = 32'h0000_3000; req = 4'b0100;
    for (int b = 0; b < 4; b++) begin
      tick();
      data[16 +: 8] = 8'h30 + 8'(b);
      #1;
      checks++; if (gnt_id !== 2'd2) begin errors++; $display("FAIL single_gnt_id b%0d: got %0d expected 2", b, gnt_id); end
      checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack b%0d: got %b expected 0100", b, ack); end
      checks++; if (fifo_din !== 8'h30 + 8'(b)) begin errors++; $display("FAIL single_din b%0d: got %h expected %h", b, fifo_din, 8'h30 + 8'(b)); end
      checks++; if (fifo_count !== 4'(b)) begin errors++; $display("FAIL single_count b%0d: got %0d expected %0d", b, fifo_count, b); end
    end
    tick(); #1;
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL single_bubble_gnt: got %b expected 0", gnt_valid); end
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_bubble_wr_en: got %b expected 0", fifo_wr_en); end
    checks++; if (fifo_count !== 4'd4) begin errors++; $display("FAIL single_final_count: got %0d expected 4", fifo_count); end
    tick(); #1;
    checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL single_regrant_valid: got %b expected 1", gnt_valid); end
    checks++; if (gnt_id !== 2'd2) begin errors++; $display("FAIL single_regrant_id: got %0d expected 2", gnt_id); end
    req = 4'b0000;
  endtask

  task automatic test_rotation();
    int exp_ids[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3, 0};
    do_reset();
    fifo_rd = 1'b1; data = 32'hA3A2_A1A0; req = 4'b1011;
    for (int i = 0; i < 13; i++) begin
      tick(); #1;
      checks++; if (gnt_id !== 2'(exp_ids[i])) begin errors++; $display("FAIL rot_gnt_id i%0d: got %0d expected %0d", i, gnt_id, exp_ids[i]); end
      checks++; if (ack !== 4'(1 << exp_ids[i])) begin errors++; $display("FAIL rot_ack i%0d: got %b expected %b", i, ack, 4'(1 << exp_ids[i])); end
      checks++; if (fifo_din !== 8'hA0 + 8'(exp_ids[i])) begin errors++; $display("FAIL rot_din i%0d: got %h expected %h", i, fifo_din, 8'hA0 + 8'(exp_ids[i])); end
    end
    req = 4'b0000; fifo_rd = 1'b0;
  endtask

  task automatic test_full_stall();
    do_reset();
    tb_push = 1'b1;
    repeat (6) tick();
    tb_push = 1'b0; data = 32'h0000_5000; req = 4'b0010;
    tick(); #1;
    checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h50) begin errors++; $display("FAIL stall_beat0: got wr_en=%b din=%h expected 1/50", fifo_wr_en, fifo_din); end
    checks++; if (fifo_count !== 4'd6) begin errors++; $display("FAIL stall_preload: got %0d expected 6", fifo_count); end
    tick(); data[8 +: 8] = 8'h51; #1;
    checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h51) begin errors++; $display("FAIL stall_beat1: got wr_en=%b din=%h expected 1/51", fifo_wr_en, fifo_din); end
    data[8 +: 8] = 8'h52;
    for (int s = 0; s < 3; s++) begin
      tick(); #1;
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL stall_wr_en s%0d: got %b expected 0", s, fifo_wr_en); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL stall_ack s%0d: got %b expected 0000", s, ack); end
      checks++; if (gnt_valid !== 1'b1 || gnt_id !== 2'd1) begin errors++; $display("FAIL stall_gnt s%0d: got valid=%b id=%0d expected 1/1", s, gnt_valid, gnt_id); end
      if (s == 2) fifo_rd = 1'b1;
    end
    tick(); #1;
    checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h52 || ack !== 4'b0010) begin errors++; $display("FAIL stall_resume: got wr_en=%b din=%h ack=%b expected 1/52/0010", fifo_wr_en, fifo_din, ack); end
`ifdef FIFO_WR_ARBITER_STATS_EN
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
`endif
    tick(); data[8 +: 8] = 8'h53; #1;
    checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h53) begin errors++; $display("FAIL stall_last: got wr_en=%b din=%h expected 1/53", fifo_wr_en, fifo_din); end
    tick(); #1;
    checks++; if (gnt_valid !== 1'b0 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL stall_release: got valid=%b wr_en=%b expected 0/0", gnt_valid, fifo_wr_en); end
    fifo_rd = 1'b0; req = 4'b0000;
`ifdef FIFO_WR_ARBITER_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0; #1;
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_cnt_clr: got %0d expected 0", stall_cnt); end
`endif
  endtask

  task automatic test_early_drop();
    do_reset();
    data = 32'hD3D2_D1D0; req = 4'b1000;
    tick(); #1;
    checks++; if (gnt_id !== 2'd3 || ack !== 4'b1000) begin errors++; $display("FAIL drop_beat0: got id=%0d ack=%b expected 3/1000", gnt_id, ack); end
    req = 4'b1001;
    tick(); #1;
    checks++; if (gnt_id !== 2'd3 || ack !== 4'b1000) begin errors++; $display("FAIL drop_beat1: got id=%0d ack=%b expected 3/1000", gnt_id, ack); end
    tick(); req = 4'b0001; #1;
    checks++; if (fifo_wr_en !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL drop_no_write: got wr_en=%b ack=%b expected 0/0000", fifo_wr_en, ack); end
    checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL drop_count: got %0d expected 2", fifo_count); end
    tick(); #1;
    checks++; if (gnt_valid !== 1'b1 || gnt_id !== 2'd0 || ack !== 4'b0001) begin errors++; $display("FAIL drop_handover: got valid=%b id=%0d ack=%b expected 1/0/0001", gnt_valid, gnt_id, ack); end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    data = 32'hE3E2_E1E0; req = 4'b0100;
    tick(); #1;
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL rstmid_beat0: got %b expected 0100", ack); end
    tick(); rst = 1'b0; #1;
    checks++; if (fifo_wr_en !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL rstmid_forced: got wr_en=%b ack=%b expected 0/0000", fifo_wr_en, ack); end
    tick(); #1;
    checks++; if (gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin errors++; $display("FAIL rstmid_dropped: got valid=%b id=%0d expected 0/0", gnt_valid, gnt_id); end
    rst = 1'b1; req = 4'b0101;
    tick(); #1;
    checks++; if (gnt_valid !== 1'b1 || gnt_id !== 2'd0 || ack !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr0: got valid=%b id=%0d ack=%b expected 1/0/0001", gnt_valid, gnt_id, ack); end
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_full_stall();
    test_early_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
